// File: rtl/g15_io_pkg.sv
// Shared types for the G-15 I/O section models: photocell frame codes,
// phototape reader states and tape motion direction.
package g15_io_pkg;

    typedef logic [4:0] photo_code_t;

    typedef enum logic {
        PR_IDLE,
        PR_FRAME
    } pr_state_t;

    typedef enum logic {
        DIR_FWD,
        DIR_REV
    } tape_dir_t;

endpackage

// File: rtl/tape_image_ram.sv
// Single-port DEPTH x 5 tape image store with a registered read port,
// written so synthesis can map it onto block RAM.
module tape_image_ram
    import g15_io_pkg::*;
#(
    parameter int DEPTH = 4096,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic          re_i,
    input  logic [AW-1:0] addr_i,
    input  photo_code_t   wdata_i,
    output photo_code_t   rdata_o
);

    photo_code_t mem [DEPTH];
    photo_code_t rdata_q;

    // No reset on the read register: it only carries data qualified elsewhere.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[addr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/phototape_reader_model.sv
// G-15 phototape reader emulation: plays a loaded 5-bit frame image onto the
// PHOTO1..5 lines at a fixed character rate under FWD/REV motion control.
module phototape_reader_model
    import g15_io_pkg::*;
#(
    parameter  int DEPTH        = 4096,
    parameter  int CHAR_CYCLES  = 400,
    parameter  int PULSE_CYCLES = 100,
    localparam int AW           = $clog2(DEPTH)
) (
    input  logic          CLOCK,
    input  logic          rst,
    input  logic          PHOTO_TAPE_FWD,
    input  logic          PHOTO_TAPE_REV,
    output logic          PHOTO1,
    output logic          PHOTO2,
    output logic          PHOTO3,
    output logic          PHOTO4,
    output logic          PHOTO5,
    input  logic          load_valid,
    input  logic [4:0]    load_data,
    output logic          load_ready,
    input  logic          load_clear,
    output logic [AW:0]   tape_len,
    output logic [AW:0]   tape_pos,
    output logic          at_end,
    output logic          at_start,
    output logic          moving
);

    localparam int CW = (CHAR_CYCLES > 1) ? $clog2(CHAR_CYCLES) : 1;

    localparam logic [CW-1:0] CNT_LAST   = CW'(CHAR_CYCLES - 1);
    localparam logic [CW-1:0] CNT_PULSE  = CW'(PULSE_CYCLES);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);
    localparam logic [AW:0]   LEN_FULL   = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   POS_ONE    = (AW + 1)'(1);
    localparam logic [AW-1:0] ADDR_ONE   = AW'(1);

    pr_state_t   state_q, state_d;
    tape_dir_t   dir_q, dir_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [AW:0] tapePos_q, tapePos_d;
    logic [AW:0] tapeLen_q, tapeLen_d;
    logic        frameValid_q, frameValid_d;

    logic        fwdReq;
    logic        revReq;
    logic        fetch;
    logic        frameOk;
    logic        ramWe;
    logic [AW-1:0] ramAddr;
    photo_code_t ramRdata;
    photo_code_t photo;
    logic        pulseOn;

    // Both motion lines high decodes to neither, i.e. stop.
    assign fwdReq = PHOTO_TAPE_FWD & ~PHOTO_TAPE_REV;
    assign revReq = PHOTO_TAPE_REV & ~PHOTO_TAPE_FWD;

    assign at_end     = (tapePos_q == tapeLen_q);
    assign at_start   = (tapePos_q == '0);
    assign moving     = (state_q != PR_IDLE);
    assign tape_len   = tapeLen_q;
    assign tape_pos   = tapePos_q;
    assign load_ready = (state_q == PR_IDLE) & ~load_clear & (tapeLen_q < LEN_FULL);

    assign fetch   = (state_q == PR_FRAME) && (cnt_q == '0);
    assign frameOk = (dir_q == DIR_FWD) ? ~at_end : ~at_start;
    assign ramWe   = load_valid & load_ready;

    // Loads only happen in IDLE and reads only in FRAME, so one port suffices.
    always_comb begin
        ramAddr = tapeLen_q[AW-1:0];
        if (state_q == PR_FRAME) begin
            if (dir_q == DIR_REV) begin
                ramAddr = tapePos_q[AW-1:0] - ADDR_ONE;
            end else begin
                ramAddr = tapePos_q[AW-1:0];
            end
        end
    end

    tape_image_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk_i   (CLOCK),
        .we_i    (ramWe),
        .re_i    (fetch),
        .addr_i  (ramAddr),
        .wdata_i (load_data),
        .rdata_o (ramRdata)
    );

    always_ff @(posedge CLOCK or posedge rst) begin
        if (rst) begin
            state_q      <= PR_IDLE;
            dir_q        <= DIR_FWD;
            cnt_q        <= '0;
            tapePos_q    <= '0;
            tapeLen_q    <= '0;
            frameValid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            dir_q        <= dir_d;
            cnt_q        <= cnt_d;
            tapePos_q    <= tapePos_d;
            tapeLen_q    <= tapeLen_d;
            frameValid_q <= frameValid_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        dir_d        = dir_q;
        cnt_d        = cnt_q;
        tapePos_d    = tapePos_q;
        tapeLen_d    = tapeLen_q;
        frameValid_d = frameValid_q;

        unique case (state_q)
            PR_IDLE: begin
                cnt_d        = '0;
                frameValid_d = 1'b0;
                if (load_clear) begin
                    tapeLen_d = '0;
                    tapePos_d = '0;
                end else if (ramWe) begin
                    tapeLen_d = tapeLen_q + POS_ONE;
                end
                if (fwdReq | revReq) begin
                    state_d = PR_FRAME;
                    dir_d   = fwdReq ? DIR_FWD : DIR_REV;
                end
            end

            PR_FRAME: begin
                if (cnt_q == '0) begin
                    frameValid_d = frameOk;
                    if (frameOk) begin
                        tapePos_d = (dir_q == DIR_FWD) ? tapePos_q + POS_ONE
                                                       : tapePos_q - POS_ONE;
                    end
                end
                // Motion lines are only sampled at the frame boundary.
                if (cnt_q == CNT_LAST) begin
                    cnt_d        = '0;
                    frameValid_d = 1'b0;
                    if (fwdReq | revReq) begin
                        dir_d = fwdReq ? DIR_FWD : DIR_REV;
                    end else begin
                        state_d = PR_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            default: begin
                state_d = PR_IDLE;
            end
        endcase
    end

    assign pulseOn = (state_q == PR_FRAME) && frameValid_q &&
                     (cnt_q != '0) && (cnt_q <= CNT_PULSE);
    assign photo   = pulseOn ? ramRdata : '0;

    assign PHOTO1 = photo[0];
    assign PHOTO2 = photo[1];
    assign PHOTO3 = photo[2];
    assign PHOTO4 = photo[3];
    assign PHOTO5 = photo[4];

endmodule

// File: tb/tb_phototape_reader_model.sv
// Directed bench for phototape_reader_model with a short frame period so
// every cycle of each frame can be compared against hand-computed values.
module tb_phototape_reader_model;

    localparam int DEPTH        = 8;
    localparam int CHAR_CYCLES  = 8;
    localparam int PULSE_CYCLES = 3;
    localparam int AW           = 3;

    logic          CLOCK;
    logic          rst;
    logic          fwd;
    logic          rev;
    logic          p1, p2, p3, p4, p5;
    logic          loadValid;
    logic [4:0]    loadData;
    logic          loadReady;
    logic          loadClear;
    logic [AW:0]   tapeLen;
    logic [AW:0]   tapePos;
    logic          atEnd;
    logic          atStart;
    logic          moving;
    logic [4:0]    photo;

    int checkCount = 0;
    int errorCount = 0;

    assign photo = {p5, p4, p3, p2, p1};

    phototape_reader_model #(
        .DEPTH        (DEPTH),
        .CHAR_CYCLES  (CHAR_CYCLES),
        .PULSE_CYCLES (PULSE_CYCLES)
    ) dut (
        .CLOCK          (CLOCK),
        .rst            (rst),
        .PHOTO_TAPE_FWD (fwd),
        .PHOTO_TAPE_REV (rev),
        .PHOTO1         (p1),
        .PHOTO2         (p2),
        .PHOTO3         (p3),
        .PHOTO4         (p4),
        .PHOTO5         (p5),
        .load_valid     (loadValid),
        .load_data      (loadData),
        .load_ready     (loadReady),
        .load_clear     (loadClear),
        .tape_len       (tapeLen),
        .tape_pos       (tapePos),
        .at_end         (atEnd),
        .at_start       (atStart),
        .moving         (moving)
    );

    initial CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLOCK);
        #1;
    endtask

    task automatic applyStimulus(input logic f, input logic r);
        fwd = f;
        rev = r;
    endtask

    task automatic loadFrame(input logic [4:0] d, input logic expReady);
        loadValid = 1'b1;
        loadData  = d;
        #1;
        checkOutput("load_ready", 32'(loadReady), 32'(expReady));
        tick();
        loadValid = 1'b0;
    endtask

    // Each frame is 8 ticks; tick 1 is the fetch, pulse on ticks 2..4.
    task automatic runFrames(input int n, input logic [24:0] pats, input logic [AW:0] expPos);
        logic [4:0] expPhoto;
        for (int f = 0; f < n; f++) begin
            for (int j = 1; j <= CHAR_CYCLES; j++) begin
                tick();
                expPhoto = (j >= 2 && j <= 1 + PULSE_CYCLES) ? pats[5*f +: 5] : 5'h00;
                checkOutput($sformatf("photo f%0d c%0d", f, j), 32'(photo), 32'(expPhoto));
            end
            checkOutput("moving", 32'(moving), 32'(1));
        end
        checkOutput("tape_pos", 32'(tapePos), 32'(expPos));
    endtask

    initial begin
        rst       = 1'b1;
        fwd       = 1'b0;
        rev       = 1'b0;
        loadValid = 1'b0;
        loadData  = 5'h00;
        loadClear = 1'b0;
        #23;
        checkOutput("rst photo", 32'(photo), 32'(0));
        checkOutput("rst load_ready", 32'(loadReady), 32'(1));
        checkOutput("rst tape_len", 32'(tapeLen), 32'(0));
        checkOutput("rst tape_pos", 32'(tapePos), 32'(0));
        checkOutput("rst moving", 32'(moving), 32'(0));
        checkOutput("rst at_start", 32'(atStart), 32'(1));
        tick();
        rst = 1'b0;
        tick();

        loadFrame(5'h01, 1'b1);
        loadFrame(5'h1F, 1'b1);
        loadFrame(5'h0A, 1'b1);
        checkOutput("len after load", 32'(tapeLen), 32'(3));
        checkOutput("pos after load", 32'(tapePos), 32'(0));
        checkOutput("photo idle", 32'(photo), 32'(0));
        checkOutput("at_end idle", 32'(atEnd), 32'(0));

        applyStimulus(1'b1, 1'b0);
        runFrames(3, {5'h0A, 5'h1F, 5'h01}, 4'd3);
        checkOutput("at_end fwd", 32'(atEnd), 32'(1));
        runFrames(2, 25'h0, 4'd3);

        applyStimulus(1'b0, 1'b1);
        runFrames(2, {5'h00, 5'h1F, 5'h0A}, 4'd1);
        applyStimulus(1'b0, 1'b0);
        tick();
        checkOutput("stop moving", 32'(moving), 32'(0));

        applyStimulus(1'b1, 1'b1);
        tick();
        tick();
        checkOutput("both moving", 32'(moving), 32'(0));
        checkOutput("both pos", 32'(tapePos), 32'(1));

        // Forward frame from pos 1, FWD dropped at cnt 2.
        applyStimulus(1'b1, 1'b0);
        for (int j = 1; j <= CHAR_CYCLES; j++) begin
            tick();
            checkOutput($sformatf("drop photo c%0d", j), 32'(photo),
                        32'((j >= 2 && j <= 4) ? 5'h1F : 5'h00));
            if (j == 3) applyStimulus(1'b0, 1'b0);
            if (j == 4) loadValid = 1'b1;
            if (j >= 4) checkOutput("ready moving", 32'(loadReady), 32'(0));
        end
        loadValid = 1'b0;
        tick();
        checkOutput("drop idle", 32'(moving), 32'(0));
        checkOutput("drop len", 32'(tapeLen), 32'(3));
        checkOutput("drop pos", 32'(tapePos), 32'(2));

        loadClear = 1'b1;
        #1;
        checkOutput("ready clear", 32'(loadReady), 32'(0));
        tick();
        loadClear = 1'b0;
        checkOutput("clear len", 32'(tapeLen), 32'(0));
        checkOutput("clear pos", 32'(tapePos), 32'(0));
        checkOutput("clear at_start", 32'(atStart), 32'(1));

        for (int i = 0; i < DEPTH; i++) loadFrame(5'(i + 3), 1'b1);
        checkOutput("full len", 32'(tapeLen), 32'(8));
        loadFrame(5'h15, 1'b0);
        checkOutput("overflow len", 32'(tapeLen), 32'(8));

        // First image frame is 5'h03; reset lands in the middle of its pulse.
        applyStimulus(1'b1, 1'b0);
        tick();
        tick();
        checkOutput("pre-rst photo", 32'(photo), 32'(5'h03));
        #2;
        rst = 1'b1;
        #1;
        checkOutput("rst photo async", 32'(photo), 32'(0));
        checkOutput("rst moving async", 32'(moving), 32'(0));
        checkOutput("rst len async", 32'(tapeLen), 32'(0));
        applyStimulus(1'b0, 1'b0);
        #2;
        rst = 1'b0;
        tick();
        checkOutput("post-rst ready", 32'(loadReady), 32'(1));

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
